// File: rtl/apb_requester_if.sv
// Bundle of request/response channel and peripheral bus signals for apb_requester.
// master = requester side, slave = core + peripheral side.
interface apb_requester_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [3:0]            req_wstb;
  logic                  req_write;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [3:0]            pstb;
  logic                  ready;
  logic                  perr;

  modport master (
    input  req_valid, req_addr, req_wdata, req_wstb, req_write, rsp_ready, prdata, ready, perr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pdata, psel, penable, pwrite, pstb
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_wstb, req_write, rsp_ready, prdata, ready, perr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pdata, psel, penable, pwrite, pstb
  );
endinterface

// File: rtl/apb_requester.sv
// Peripheral bus initiator: one request at a time, SETUP/ACCESS sequencing,
// response return and a watchdog that aborts accesses that never complete.
module apb_requester #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic pclk,
  input  logic presetn,
  apb_requester_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Counter only has to reach TIMEOUT-1; it saturates so it can never wrap.
  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam bit               WDOG_EN  = (TIMEOUT != 0);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;

  // Transaction sequencer; every output is a register updated here.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= {DATA_WIDTH{1'b0}};
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= {ADDR_WIDTH{1'b0}};
      bus.pdata     <= {DATA_WIDTH{1'b0}};
      bus.pstb      <= 4'b0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.paddr     <= bus.req_addr;
            bus.pdata     <= bus.req_wdata;
            bus.pstb      <= bus.req_wstb;
            bus.pwrite    <= bus.req_write;
            bus.psel      <= 1'b1;
            bus.penable   <= 1'b0;
            bus.req_ready <= 1'b0;
            state_r       <= SETUP;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        SETUP: begin
          bus.penable <= 1'b1;
          cnt_r       <= {CNT_W{1'b0}};
          state_r     <= ACCESS;
        end
        ACCESS: begin
          // A completion on the watchdog's last cycle still counts as normal.
          if (bus.ready) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_err   <= bus.perr;
            bus.rsp_rdata <= bus.pwrite ? {DATA_WIDTH{1'b0}} : bus.prdata;
            bus.rsp_valid <= 1'b1;
            state_r       <= RESP;
          end else if (WDOG_EN && (cnt_r == CNT_LAST)) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= {DATA_WIDTH{1'b0}};
            bus.rsp_valid <= 1'b1;
            state_r       <= RESP;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state_r       <= IDLE;
          end else begin
            bus.rsp_valid <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: a vector table of complete transactions plus
// hand-written backpressure, idle-ready and mid-access reset sequences.
module tb_apb_requester;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        sel;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstb;
  logic        req_write;
  logic        rsp_ready;
  logic [31:0] prdata;
  logic        ready;
  logic        perr;

  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_psel, o_penable, o_pwrite;
  logic [31:0] o_rsp_rdata, o_paddr, o_pdata;
  logic [3:0]  o_pstb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pclk = ~pclk;

  apb_requester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
  apb_requester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();

  apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(255)) dut0 (
    .pclk(pclk), .presetn(presetn), .bus(if0)
  );
  apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut1 (
    .pclk(pclk), .presetn(presetn), .bus(if1)
  );

  assign if0.req_valid = req_valid & ~sel;
  assign if1.req_valid = req_valid & sel;
  assign if0.ready     = ready & ~sel;
  assign if1.ready     = ready & sel;
  assign if0.req_addr  = req_addr;   assign if1.req_addr  = req_addr;
  assign if0.req_wdata = req_wdata;  assign if1.req_wdata = req_wdata;
  assign if0.req_wstb  = req_wstb;   assign if1.req_wstb  = req_wstb;
  assign if0.req_write = req_write;  assign if1.req_write = req_write;
  assign if0.rsp_ready = rsp_ready;  assign if1.rsp_ready = rsp_ready;
  assign if0.prdata    = prdata;     assign if1.prdata    = prdata;
  assign if0.perr      = perr;       assign if1.perr      = perr;

  assign o_req_ready = sel ? if1.req_ready : if0.req_ready;
  assign o_rsp_valid = sel ? if1.rsp_valid : if0.rsp_valid;
  assign o_rsp_err   = sel ? if1.rsp_err   : if0.rsp_err;
  assign o_rsp_rdata = sel ? if1.rsp_rdata : if0.rsp_rdata;
  assign o_psel      = sel ? if1.psel      : if0.psel;
  assign o_penable   = sel ? if1.penable   : if0.penable;
  assign o_pwrite    = sel ? if1.pwrite    : if0.pwrite;
  assign o_paddr     = sel ? if1.paddr     : if0.paddr;
  assign o_pdata     = sel ? if1.pdata     : if0.pdata;
  assign o_pstb      = sel ? if1.pstb      : if0.pstb;

  typedef struct {
    bit          dut;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    int          wait_n;     // ACCESS cycle on which ready is raised; 0 = never
    logic [31:0] prdata;
    bit          perr;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          exp_pen;    // expected number of cycles with penable high
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_psel(input string name);
    int cyc = 0;
    do begin
      @(negedge pclk);
      cyc++;
    end while (!o_psel && cyc < 20);
    chk(name, {31'd0, o_psel}, 32'd1);
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int pen = 0;
    bit bad = 1'b0;
    @(negedge pclk);
    sel = v.dut; req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
    req_wdata = v.wdata; req_wstb = v.wstb; prdata = v.prdata;
    ready = 1'b0; perr = 1'b0;
    wait_psel($sformatf("v%0d_accept", idx));
    req_valid = 1'b0;
    chk($sformatf("v%0d_setup_penable", idx), {31'd0, o_penable}, 32'd0);
    chk($sformatf("v%0d_setup_paddr", idx), o_paddr, v.addr);
    chk($sformatf("v%0d_setup_pdata", idx), o_pdata, v.wdata);
    chk($sformatf("v%0d_setup_pstb_pwrite", idx), {27'd0, o_pstb, o_pwrite}, {27'd0, v.wstb, v.wr});
    chk($sformatf("v%0d_setup_req_ready", idx), {31'd0, o_req_ready}, 32'd0);
    do begin
      @(negedge pclk);
      ready = 1'b0; perr = 1'b0;
      if (o_penable) begin
        pen++;
        if (!o_psel || o_paddr !== v.addr || o_pwrite !== v.wr ||
            o_pdata !== v.wdata || o_pstb !== v.wstb) bad = 1'b1;
        if (pen == v.wait_n) begin
          ready = 1'b1; perr = v.perr;
        end
      end
    end while (o_penable && pen < 300);
    chk($sformatf("v%0d_penable_cycles", idx), pen, v.exp_pen);
    chk($sformatf("v%0d_access_hold", idx), {31'd0, bad}, 32'd0);
    chk($sformatf("v%0d_psel_drop", idx), {31'd0, o_psel}, 32'd0);
    chk($sformatf("v%0d_rsp_valid", idx), {31'd0, o_rsp_valid}, 32'd1);
    chk($sformatf("v%0d_rsp_err", idx), {31'd0, o_rsp_err}, {31'd0, v.exp_err});
    chk($sformatf("v%0d_rsp_rdata", idx), o_rsp_rdata, v.exp_rdata);
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_rsp_done", idx), {30'd0, o_rsp_valid, o_req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    //          dut wr  addr          wdata         wstb     wt prdata        perr err rdata         pen
    vecs[0] = '{1'b0, 1'b1, 32'h1000_0000, 32'h0000_0041, 4'b0001, 1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1};
    vecs[1] = '{1'b0, 1'b0, 32'h2000_0004, 32'h0000_0000, 4'b1111, 5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 5};
    vecs[2] = '{1'b0, 1'b0, 32'h3000_0008, 32'h0000_0000, 4'b1111, 2, 32'h0BAD_F00D, 1'b1, 1'b1, 32'h0BAD_F00D, 2};
    vecs[3] = '{1'b0, 1'b1, 32'h3000_000C, 32'h1234_5678, 4'b1100, 1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1};
    vecs[4] = '{1'b0, 1'b1, 32'h3000_0010, 32'h8765_4321, 4'b1111, 3, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 3};
    vecs[5] = '{1'b1, 1'b0, 32'h4000_0000, 32'h0000_0000, 4'b1111, 0, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0000_0000, 4};
    vecs[6] = '{1'b1, 1'b0, 32'h4000_0004, 32'h0000_0000, 4'b1111, 4, 32'h5A5A_A5A5, 1'b0, 1'b0, 32'h5A5A_A5A5, 4};
    vecs[7] = '{1'b1, 1'b1, 32'h4000_0008, 32'h0000_00FF, 4'b0011, 2, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 2};

    presetn = 1'b0; sel = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_wstb = 4'd0; req_write = 1'b0; rsp_ready = 1'b0; prdata = 32'd0; ready = 1'b0; perr = 1'b0;

    // Reset state of both instances
    repeat (2) @(negedge pclk);
    chk("rst_ctrl0", {26'd0, if0.req_ready, if0.rsp_valid, if0.rsp_err, if0.psel, if0.penable, if0.pwrite}, 32'd0);
    chk("rst_ctrl1", {26'd0, if1.req_ready, if1.rsp_valid, if1.rsp_err, if1.psel, if1.penable, if1.pwrite}, 32'd0);
    chk("rst_data0", if0.paddr | if0.pdata | if0.rsp_rdata | {28'd0, if0.pstb}, 32'd0);
    presetn = 1'b1;
    #1 chk("rst_req_ready_release", {31'd0, o_req_ready}, 32'd0);
    @(negedge pclk);
    chk("rst_req_ready_edge", {31'd0, o_req_ready}, 32'd1);

    for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

    // ready while idle is ignored
    @(negedge pclk);
    sel = 1'b0; ready = 1'b1;
    repeat (3) @(negedge pclk);
    ready = 1'b0;
    chk("idle_ready_ignored", {30'd0, o_rsp_valid, o_psel}, 32'd0);

    // Backpressure with a second write queued behind the response
    @(negedge pclk);
    sel = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h5000_0000;
    req_wdata = 32'hAAAA_5555; req_wstb = 4'b1111; prdata = 32'h1111_1111;
    wait_psel("bp_accept1");
    req_addr = 32'h6000_0010; req_wdata = 32'h0000_00C3; req_wstb = 4'b0010;
    @(negedge pclk);
    chk("bp_penable1", {31'd0, o_penable}, 32'd1);
    ready = 1'b1;
    @(negedge pclk);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge pclk);
      chk($sformatf("bp_hold%0d_rsp", k), {29'd0, o_rsp_valid, o_rsp_err, o_req_ready}, 32'd4);
      chk($sformatf("bp_hold%0d_rdata", k), o_rsp_rdata, 32'd0);
      chk($sformatf("bp_hold%0d_psel", k), {31'd0, o_psel}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk("bp_gap", {30'd0, o_rsp_valid, o_psel}, 32'd0);
    chk("bp_req_ready", {31'd0, o_req_ready}, 32'd1);
    @(negedge pclk);
    req_valid = 1'b0;
    chk("bp_accept2", {31'd0, o_psel}, 32'd1);
    chk("bp_addr2", o_paddr, 32'h6000_0010);
    chk("bp_data2", o_pdata, 32'h0000_00C3);
    chk("bp_stb2", {28'd0, o_pstb}, 32'h2);
    @(negedge pclk);
    ready = 1'b1;
    @(negedge pclk);
    ready = 1'b0;
    chk("bp_rsp2", {30'd0, o_rsp_valid, o_rsp_err}, 32'd2);
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;

    // Reset in the middle of an access
    @(negedge pclk);
    sel = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h7000_0000;
    wait_psel("rst_mid_accept");
    req_valid = 1'b0;
    @(negedge pclk);
    chk("rst_mid_penable", {31'd0, o_penable}, 32'd1);
    #2 presetn = 1'b0;
    #1 chk("rst_mid_async", {28'd0, o_psel, o_penable, o_rsp_valid, o_req_ready}, 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    #1 chk("rst_mid_release", {31'd0, o_req_ready}, 32'd0);
    @(negedge pclk);
    chk("rst_mid_req_ready", {31'd0, o_req_ready}, 32'd1);
    repeat (3) @(negedge pclk);
    chk("rst_mid_no_stale", {30'd0, o_rsp_valid, o_psel}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
